// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receiver with a two-flop rx synchroniser and
// registered word/status outputs. Define UART_RX_PARITY_EN to add the parity bit stage.
module uart_rx_ctrl #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(0);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  function automatic logic parity_mismatch(input logic [DATA_W-1:0] word, input logic par_bit);
    parity_mismatch = (^word) ^ par_bit ^ (PARITY_ODD != 0);
  endfunction

  logic              rx_meta_r;
  logic              rx_sync_r;
  state_t            state_r;
  state_t            state_next_s;
  logic [TICK_W-1:0] tick_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic              frame_acc_r;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;
  logic              frame_err_r;
  logic              busy_r;
  logic              tick_end_s;
  logic              last_bit_s;
  logic              last_stop_s;
  logic              sample_s;
  logic              shift_en_s;
  logic              stop_en_s;
  logic              final_s;
`ifdef UART_RX_PARITY_EN
  logic              par_en_s;
  logic              par_bit_r;
  logic              parity_err_r;
`endif

  assign last_bit_s  = (bit_cnt_r == DATA_LAST);
  assign last_stop_s = (bit_cnt_r == STOP_LAST);

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Half-bit wait in START centres every later sample in its bit cell.
  always_comb begin
    if (state_r == ST_START) begin
      tick_end_s = (tick_cnt_r == HALF_LAST);
    end else begin
      tick_end_s = (tick_cnt_r == FULL_LAST);
    end
  end

  // State register; busy is registered from the next state so it tracks state_r exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
    end
  end

  // Next-state logic; every transition waits for a baud tick.
  always_comb begin
    state_next_s = state_r;
    if (baud_tick) begin
      case (state_r)
        ST_IDLE: begin
          if (!rx_sync_r) state_next_s = ST_START;
          else            state_next_s = ST_IDLE;
        end
        ST_START: begin
          if (tick_end_s) state_next_s = rx_sync_r ? ST_IDLE : ST_DATA;
          else            state_next_s = ST_START;
        end
        ST_DATA: begin
          if (tick_end_s && last_bit_s) begin
`ifdef UART_RX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            state_next_s = ST_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick_end_s) state_next_s = ST_STOP;
          else            state_next_s = ST_PARITY;
        end
`endif
        ST_STOP: begin
          if (tick_end_s && last_stop_s) state_next_s = rx_sync_r ? ST_IDLE : ST_WAIT_HIGH;
          else                           state_next_s = ST_STOP;
        end
        ST_WAIT_HIGH: begin
          if (rx_sync_r) state_next_s = ST_IDLE;
          else           state_next_s = ST_WAIT_HIGH;
        end
        default: state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM output strobes for the datapath.
  always_comb begin
    sample_s   = baud_tick & tick_end_s;
    shift_en_s = 1'b0;
    stop_en_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_s   = 1'b0;
`endif
    case (state_r)
      ST_DATA:   shift_en_s = sample_s;
`ifdef UART_RX_PARITY_EN
      ST_PARITY: par_en_s   = sample_s;
`endif
      ST_STOP:   stop_en_s  = sample_s;
      default: begin
        shift_en_s = 1'b0;
        stop_en_s  = 1'b0;
      end
    endcase
    final_s = stop_en_s & last_stop_s;
  end

  // Tick and bit counters; the bit counter is reused to count stop bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= TICK_ZERO;
      bit_cnt_r  <= BIT_ZERO;
    end else if (baud_tick) begin
      if (state_r == ST_IDLE || state_r == ST_WAIT_HIGH || tick_end_s) tick_cnt_r <= TICK_ZERO;
      else                                                             tick_cnt_r <= tick_cnt_r + TICK_ONE;
      if (state_r == ST_IDLE) bit_cnt_r <= BIT_ZERO;
      else if (shift_en_s)    bit_cnt_r <= last_bit_s ? BIT_ZERO : bit_cnt_r + BIT_ONE;
      else if (stop_en_s)     bit_cnt_r <= last_stop_s ? BIT_ZERO : bit_cnt_r + BIT_ONE;
      else                    bit_cnt_r <= bit_cnt_r;
    end else begin
      tick_cnt_r <= tick_cnt_r;
      bit_cnt_r  <= bit_cnt_r;
    end
  end

  // Receive shift register (LSB arrives first) and stop-bit error accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r     <= {DATA_W{1'b0}};
      frame_acc_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r   <= 1'b0;
`endif
    end else begin
      if (shift_en_s) shift_r <= {rx_sync_r, shift_r[DATA_W-1:1]};
      else            shift_r <= shift_r;
      if (state_r == ST_IDLE) frame_acc_r <= 1'b0;
      else if (stop_en_s)     frame_acc_r <= frame_acc_r | ~rx_sync_r;
      else                    frame_acc_r <= frame_acc_r;
`ifdef UART_RX_PARITY_EN
      if (par_en_s) par_bit_r <= rx_sync_r;
      else          par_bit_r <= par_bit_r;
`endif
    end
  end

  // Result registers: loaded on the final stop sample, held until the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_r   <= {DATA_W{1'b0}};
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      data_valid_r <= final_s;
      if (final_s) begin
        data_out_r   <= shift_r;
        frame_err_r  <= frame_acc_r | ~rx_sync_r;
`ifdef UART_RX_PARITY_EN
        parity_err_r <= parity_mismatch(shift_r, par_bit_r);
`endif
      end else begin
        data_out_r   <= data_out_r;
        frame_err_r  <= frame_err_r;
`ifdef UART_RX_PARITY_EN
        parity_err_r <= parity_err_r;
`endif
      end
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign frame_err  = frame_err_r;
  assign busy       = busy_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal range 5..16.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud_tick pulses per bit period, even value, legal range 4..32.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame, legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense: 0 even, 1 odd.
REQ-005 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port baud_tick  input  1  single-cycle oversample strobe.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port data_out  output  DATA_W  last received word, LSB received first.
REQ-010 SHALL have port data_valid  output  1  one-clk pulse, word complete.
REQ-011 SHALL have port parity_err  output  1  parity mismatch, qualified by data_valid.
REQ-012 SHALL have port frame_err  output  1  stop bit sampled low, qualified by data_valid.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL synchronise rx through two flops before any use; all sampling uses the synchronised value.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-016 IDLE: on synchronised rx low, go to START and clear the tick counter.
REQ-017 START: after OVERSAMPLE/2 ticks, sample rx. Low goes to DATA. High is a false start and returns to IDLE with no output pulse.
REQ-018 DATA: sample one bit every OVERSAMPLE ticks at mid-bit, shifting LSB first. After DATA_W bits, go to PARITY (parity enabled) or STOP.
REQ-019 PARITY: sample one bit after OVERSAMPLE ticks; parity_err = (XOR of data bits XOR parity bit XOR PARITY_ODD) != 0.
REQ-020 STOP: sample STOP_BITS bits, OVERSAMPLE ticks apart; any low sample sets frame_err.
REQ-021 On the clk of the final stop-bit sample, SHALL update data_out, parity_err and frame_err and pulse data_valid for exactly one clk.
REQ-022 After the final stop sample, SHALL go to IDLE if the sample was high, else to WAIT_HIGH.
REQ-023 WAIT_HIGH SHALL stay until synchronised rx is high, then go to IDLE; a break SHALL NOT produce repeated frames.
REQ-024 Counters SHALL advance only on clks with baud_tick high; with baud_tick low, state, counters and outputs SHALL hold.
REQ-025 Bit counter width SHALL be clog2(DATA_W+1) and tick counter width clog2(OVERSAMPLE); both wrap to 0 on bit advance.
REQ-026 data_out, parity_err and frame_err SHALL hold their values between data_valid pulses.

Reset
REQ-027 On reset low, SHALL enter IDLE immediately, including mid-frame. Clear all counters, shift register, and both synchroniser flops (set to 1).
REQ-028 Reset values SHALL be: data_out 0, data_valid 0, parity_err 0, frame_err 0, busy 0.
REQ-029 A partially received frame interrupted by reset SHALL produce no data_valid pulse.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, SHALL implement the PARITY state and the parity_err check.
REQ-031 Without UART_RX_PARITY_EN, SHALL omit the PARITY state (DATA goes directly to STOP) and SHALL tie parity_err to 0; the port remains present.

Verification
REQ-032 Defaults, parity on, baud_tick every clk: frame 0xA5 with parity 0 and stop 1 -> data_out=0xA5, data_valid one clk, parity_err=0, frame_err=0.
REQ-033 Same setup, frame 0xA5 with parity 1 -> data_out=0xA5, parity_err=1, frame_err=0.
REQ-034 rx low for 6 ticks then high (glitch) -> no data_valid; busy returns to 0 within OVERSAMPLE/2+3 clks.
REQ-035 Frame 0x3C with stop bit 0, rx held low 50 bit-times -> exactly one data_valid with frame_err=1, state WAIT_HIGH until rx high, then a next frame 0x0F is received correctly.
REQ-036 DATA_W=16, STOP_BITS=2, macro undefined: frame 0xBEEF, second stop bit low -> data_out=0xBEEF, frame_err=1, parity_err=0.
REQ-037 reset asserted after 4 data bits of a frame, released, then frame 0x81 sent -> no pulse for the aborted frame, then data_out=0x81 with a single data_valid.
